// File: rtl/dkong3_obj_dma.sv
// ---------------------------------------------------------------------------
// dkong3_obj_dma
//   Sprite-list DMA controller for the main CPU bus. On a rising edge of the
//   DMA RDY latch bit it requests the bus (BUSRQ/BUSAK). It then copies LEN
//   bytes from work RAM (SRC_BASE..) to OBJ RAM (DST_BASE..) and releases
//   the bus. Each byte takes five I_CEN ticks: RD1 RD2 WR1 WR2 WR3.
//
// Ports
//   I_CLK12M   system clock, all state advances on posedge
//   I_RESET    asynchronous active-high reset
//   I_CEN      bus-step enable; the FSM only advances when 1
//   I_RDY      DMA RDY latch bit; a rising edge arms a transfer
//   O_BUSRQ_n  bus request to main CPU (active-low)
//   I_BUSAK_n  bus acknowledge from main CPU (active-low)
//   O_BUSEN    1 while this block owns the bus (top level muxes AB/DB/strobes)
//   O_AB       bus address (0 when not owning the bus)
//   O_DB       write data (0 when not owning the bus)
//   I_DB       read data from the bus
//   O_MREQ_n   memory request strobe (active-low)
//   O_RD_n     read strobe (active-low)
//   O_WR_n     write strobe (active-low)
//   O_BUSY     1 from arm until the bus is released
//   O_DONE     one-clock pulse when a full, non-aborted transfer completes
// ---------------------------------------------------------------------------
module dkong3_obj_dma #(
    parameter logic [15:0] SRC_BASE = 16'h6900,
    parameter logic [15:0] DST_BASE = 16'h7000,
    parameter logic [9:0]  LEN      = 10'd384
) (
    input  logic        I_CLK12M,
    input  logic        I_RESET,
    input  logic        I_CEN,
    input  logic        I_RDY,
    output logic        O_BUSRQ_n,
    input  logic        I_BUSAK_n,
    output logic        O_BUSEN,
    output logic [15:0] O_AB,
    output logic [7:0]  O_DB,
    input  logic [7:0]  I_DB,
    output logic        O_MREQ_n,
    output logic        O_RD_n,
    output logic        O_WR_n,
    output logic        O_BUSY,
    output logic        O_DONE
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD1, S_RD2, S_WR1, S_WR2, S_WR3, S_REL
    } state_t;

    state_t     state;
    logic [9:0] count;
    logic       armed;
    logic       aborted;
    logic       rdy_prev;
    logic       rdy_edge;
    logic [9:0] count_next;

    assign rdy_edge   = I_RDY & ~rdy_prev;
    assign count_next = count + 10'd1;

    // NOTE: every register below uses non-blocking assignment so that all
    // state updates see the values from before the clock edge.
    always_ff @(posedge I_CLK12M or posedge I_RESET) begin
        if (I_RESET) begin
            state     <= S_IDLE;
            count     <= '0;
            armed     <= 1'b0;
            aborted   <= 1'b0;
            rdy_prev  <= 1'b0;
            O_BUSRQ_n <= 1'b1;
            O_BUSEN   <= 1'b0;
            O_AB      <= '0;
            O_DB      <= '0;
            O_MREQ_n  <= 1'b1;
            O_RD_n    <= 1'b1;
            O_WR_n    <= 1'b1;
            O_BUSY    <= 1'b0;
            O_DONE    <= 1'b0;
        end else begin
            // Edge detector and DONE pulse run at full clock rate, not I_CEN rate.
            rdy_prev <= I_RDY;
            O_DONE   <= 1'b0;
            if (state == S_IDLE && rdy_edge)
                armed <= 1'b1;

            if (I_CEN) begin
                case (state)
                    S_IDLE: begin
                        if (armed) begin
                            armed     <= 1'b0;
                            aborted   <= 1'b0;
                            O_BUSY    <= 1'b1;
                            O_BUSRQ_n <= 1'b0;
                            state     <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        // RDY withdrawn before the grant: give up without touching the bus.
                        if (!I_RDY) begin
                            aborted   <= 1'b1;
                            O_BUSRQ_n <= 1'b1;
                            state     <= S_REL;
                        end else if (!I_BUSAK_n) begin
                            O_BUSEN  <= 1'b1;
                            O_AB     <= SRC_BASE + {6'd0, count};
                            O_MREQ_n <= 1'b0;
                            O_RD_n   <= 1'b0;
                            state    <= S_RD1;
                        end
                    end
                    S_RD1: state <= S_RD2;
                    S_RD2: begin
                        // The output data register doubles as the byte latch.
                        O_DB   <= I_DB;
                        O_AB   <= DST_BASE + {6'd0, count};
                        O_RD_n <= 1'b1;
                        state  <= S_WR1;
                    end
                    S_WR1: begin
                        O_WR_n <= 1'b0;
                        state  <= S_WR2;
                    end
                    S_WR2: begin
                        O_WR_n   <= 1'b1;
                        O_MREQ_n <= 1'b1;
                        state    <= S_WR3;
                    end
                    S_WR3: begin
                        // Abort is only honoured here, so a byte already read is always written.
                        if (count == LEN - 10'd1 || !I_RDY) begin
                            aborted   <= (count != LEN - 10'd1);
                            O_BUSEN   <= 1'b0;
                            O_BUSRQ_n <= 1'b1;
                            O_AB      <= '0;
                            O_DB      <= '0;
                            state     <= S_REL;
                        end else begin
                            count    <= count_next;
                            O_AB     <= SRC_BASE + {6'd0, count_next};
                            O_DB     <= '0;
                            O_MREQ_n <= 1'b0;
                            O_RD_n   <= 1'b0;
                            state    <= S_RD1;
                        end
                    end
                    S_REL: begin
                        if (I_BUSAK_n) begin
                            O_BUSY <= 1'b0;
                            O_DONE <= ~aborted;
                            count  <= '0;
                            state  <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dkong3_obj_dma.sv
module tb_dkong3_obj_dma;

    localparam logic [9:0] LEN = 10'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        rdy;
    logic        busrq_n;
    logic        busak_n;
    logic        busen;
    logic [15:0] ab;
    logic [7:0]  db_out;
    logic [7:0]  db_in;
    logic        mreq_n;
    logic        rd_n;
    logic        wr_n;
    logic        busy;
    logic        done;

    dkong3_obj_dma #(.SRC_BASE(16'h6900), .DST_BASE(16'h7000), .LEN(LEN)) dut (
        .I_CLK12M (clk),
        .I_RESET  (rst),
        .I_CEN    (cen),
        .I_RDY    (rdy),
        .O_BUSRQ_n(busrq_n),
        .I_BUSAK_n(busak_n),
        .O_BUSEN  (busen),
        .O_AB     (ab),
        .O_DB     (db_out),
        .I_DB     (db_in),
        .O_MREQ_n (mreq_n),
        .O_RD_n   (rd_n),
        .O_WR_n   (wr_n),
        .O_BUSY   (busy),
        .O_DONE   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] src_mem[4];
    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         cen_period = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source memory: answers reads of 6900..6903.
    assign db_in = (!rd_n && ab >= 16'h6900 && ab < 16'h6904) ? src_mem[ab[1:0]] : 8'h00;

    // CPU model: BUSAK_n follows BUSRQ_n two cycles later.
    initial begin
        logic sr1;
        sr1 = 1'b1;
        busak_n = 1'b1;
        forever begin
            @(negedge clk);
            busak_n = sr1;
            sr1 = busrq_n;
        end
    end

    // Bus-step enable: one tick every cen_period clocks.
    initial begin
        int cnt;
        cnt = 0;
        cen = 1'b1;
        forever begin
            @(negedge clk);
            cen = (cnt == 0);
            cnt = (cnt + 1) % cen_period;
        end
    end

    // Monitor: pops expected writes on each WR_n falling edge.
    initial begin
        logic prev_wr;
        int   low_len;
        wr_t  e;
        prev_wr = 1'b1;
        low_len = 0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!wr_n && prev_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {16'h0, ab}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", ab, e.addr);
                    check("wr_data", db_out, e.data);
                    check("wr_rd_high", rd_n, 1'b1);
                    check("wr_busen", busen, 1'b1);
                end
            end
            if (!wr_n) low_len++;
            if (wr_n && !prev_wr) begin
                check("wr_low_len", low_len, cen_period);
                low_len = 0;
            end
            prev_wr = wr_n;
        end
    end

    task automatic load_and_expect(input logic [7:0] d0, d1, d2, d3, input int n_wr);
        wr_t e;
        src_mem[0] = d0; src_mem[1] = d1; src_mem[2] = d2; src_mem[3] = d3;
        for (int i = 0; i < n_wr; i++) begin
            e.addr = 16'h7000 + 16'(i);
            e.data = src_mem[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, (n < 1000), 1'b1);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_read_at(input logic [15:0] a, input string name);
        int n;
        n = 0;
        while (!(ab == a && !rd_n) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_read_timeout"}, (n < 1000), 1'b1);
    endtask

    task automatic run_case(input string name, input int exp_done);
        done_cnt = 0;
        rdy = 1'b1;
        wait_idle(name);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_done_cnt"}, done_cnt, exp_done);
        check({name, "_busrq_n"}, busrq_n, 1'b1);
        check({name, "_busy"}, busy, 1'b0);
        rdy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        rdy = 1'b0;
        src_mem[0] = 8'h0; src_mem[1] = 8'h0; src_mem[2] = 8'h0; src_mem[3] = 8'h0;
        repeat (3) @(negedge clk);
        check("rst_busrq_n", busrq_n, 1'b1);
        check("rst_busen", busen, 1'b0);
        check("rst_ab", ab, 16'h0);
        check("rst_strobes", {mreq_n, rd_n, wr_n}, 3'b111);
        check("rst_busy_done", {busy, done}, 2'b00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: basic transfer, constant CEN.
        load_and_expect(8'h11, 8'h22, 8'h33, 8'h44, 4);
        run_case("basic", 1);

        // 2: data pattern.
        load_and_expect(8'hA5, 8'h5A, 8'hFF, 8'h00, 4);
        run_case("data", 1);

        // 3: abort while byte 1 is being read; 7001 still written.
        load_and_expect(8'h12, 8'h34, 8'h56, 8'h78, 2);
        done_cnt = 0;
        rdy = 1'b1;
        wait_read_at(16'h6901, "abort");
        rdy = 1'b0;
        wait_idle("abort");
        check("abort_queue_empty", exp_q.size(), 0);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_busak_n", busak_n, 1'b1);
        repeat (4) @(negedge clk);

        // 4: second RDY rising edge mid-transfer is ignored.
        load_and_expect(8'h9A, 8'hBC, 8'hDE, 8'hF0, 4);
        done_cnt = 0;
        rdy = 1'b1;
        wait_read_at(16'h6901, "reedge");
        rdy = 1'b0;
        @(negedge clk);
        rdy = 1'b1;
        wait_idle("reedge");
        check("reedge_queue_empty", exp_q.size(), 0);
        check("reedge_done_cnt", done_cnt, 1);
        check("reedge_busy", busy, 1'b0);
        rdy = 1'b0;
        repeat (4) @(negedge clk);

        // 5: CEN every third clock.
        cen_period = 3;
        load_and_expect(8'h01, 8'h80, 8'h7E, 8'hC3, 4);
        run_case("cen3", 1);
        cen_period = 1;
        repeat (4) @(negedge clk);

        // 6: reset during WR2 of byte 0, then restart from count 0.
        load_and_expect(8'h5C, 8'h00, 8'h00, 8'h00, 1);
        rdy = 1'b1;
        n = 0;
        while (wr_n && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_wr_timeout", (n < 1000), 1'b1);
        #2;
        rst = 1'b1;
        rdy = 1'b0;
        #1;
        check("rstmid_wr_n", wr_n, 1'b1);
        check("rstmid_busrq_n", busrq_n, 1'b1);
        check("rstmid_busen", busen, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_queue_empty", exp_q.size(), 0);
        load_and_expect(8'hE1, 8'hE2, 8'hE3, 8'hE4, 4);
        run_case("restart", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
